dmem_bram: RTL
==============

DMEM_BRAM -- requirements
Module: dmem_bram

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter DEPTH, default 1024: number of words.
REQ-004 Parameter ADDR_WIDTH, default 10: word-address width; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  DATA_WIDTH/8  byte-lane write enables
- rsp_valid  out  1  read data valid
- rsp_rdata  out  DATA_WIDTH  read data
- rsp_err  out  1  out-of-range access flag
- init_busy  out  1  clear sweep in progress

Function
REQ-006 A request SHALL be accepted on a rising clk edge where req_valid=1 and req_ready=1; at most one per cycle.
REQ-007 An accepted write SHALL update, at that edge, only the byte lanes whose req_wstrb bit is 1; wstrb=0 SHALL be accepted with no memory change.
REQ-008 An accepted read SHALL drive rsp_rdata with mem[req_addr] and pulse rsp_valid=1 for exactly one cycle, starting on the edge following acceptance (latency 1).
REQ-009 Writes SHALL NOT assert rsp_valid.
REQ-010 rsp_rdata SHALL hold its last value when rsp_valid=0; there is no response backpressure.
REQ-011 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-012 An access with req_addr >= DEPTH SHALL be accepted, SHALL NOT modify memory, and SHALL pulse rsp_err=1 for one cycle on the next edge; for a read it SHALL also pulse rsp_valid with rsp_rdata=0.
REQ-013 A two-state FSM, CLEAR and IDLE, SHALL control the block; req_ready=1 only in IDLE, and init_busy=1 only in CLEAR.
REQ-014 In CLEAR with rst=0, the block SHALL zero word clr_ptr on each edge and increment clr_ptr; after writing word DEPTH-1, the FSM SHALL move to IDLE.
REQ-015 req_ready SHALL therefore rise exactly DEPTH cycles after the first edge with rst=0.
REQ-016 req_valid during CLEAR SHALL be ignored.

Reset
REQ-017 On any edge with rst=1, the block SHALL set state=CLEAR, clr_ptr=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and write no memory word.
REQ-018 Reset asserted during a pending read or mid-sweep SHALL drop the response and restart the sweep from word 0.

Configuration
REQ-019 With macro DMEM_BRAM_DEBUG_PORT_EN defined, the block SHALL add input debug_addr [ADDR_WIDTH] and output debug_data [DATA_WIDTH], where debug_data is a combinational read of mem[debug_addr] that does not affect the request port.
REQ-020 Without DMEM_BRAM_DEBUG_PORT_EN, those ports and all associated logic SHALL be absent.

Structure
REQ-021 Default DATA_WIDTH, DEPTH and ADDR_WIDTH, and the CLEAR/IDLE state encodings, SHALL reside in the shared rv32i parameter include.
REQ-022 The clear sequencer (FSM plus clr_ptr) SHALL be a sub-module named dmem_clear_seq; the storage array and byte-lane write logic SHALL remain in dmem_bram.

Verification
REQ-023 Release rst, then count cycles: init_busy=1 and req_ready=0 for exactly 1024 cycles, then req_ready=1; a read of address 5 returns 0x00000000.
REQ-024 Write addr 3 with data 0xDEADBEEF and wstrb 4'b1111, then write addr 3 with data 0x00AA0000 and wstrb 4'b0100, then read addr 3 -> rsp_valid one cycle later with rsp_rdata=0xDEAABEEF.
REQ-025 Write addr 7 with data 0x12345678, then read addr 7 on the very next cycle -> rsp_rdata=0x12345678, and rsp_valid high for exactly one cycle.
REQ-026 With DEPTH=1000 and ADDR_WIDTH=10, write addr 1010, then read addr 1010 -> rsp_err pulses on both accesses, the read returns 0, and word 1010 mod 1024 is unchanged.
REQ-027 Assert rst for 1 cycle at sweep pointer 500 and on the cycle after a read accept -> no rsp_valid, and ready rises 1024 cycles after rst falls.
REQ-028 With DMEM_BRAM_DEBUG_PORT_EN defined, write addr 9 with 0xCAFEF00D, then set debug_addr=9 -> debug_data=0xCAFEF00D in the same cycle.

Source files
------------

// File: rtl/dmem_bram_pkg.sv
// Shared rv32i data-memory parameters: default geometry and clear-sequencer state encodings.
// Imported by the interface, the clear sequencer and the dmem_bram top.
package dmem_bram_pkg;

    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_DEPTH      = 1024;
    localparam int DMEM_ADDR_WIDTH = 10;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clearState_e;

endpackage

// File: rtl/dmem_bram_if.sv
// Request/response bundle for dmem_bram; the master issues requests, the slave is the memory.
interface dmem_bram_if #(
    parameter int DATA_WIDTH = dmem_bram_pkg::DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = dmem_bram_pkg::DMEM_ADDR_WIDTH
);
    import dmem_bram_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    init_busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

endinterface

// File: rtl/dmem_bram_clear_seq.sv
// Clear sequencer for dmem_bram: after reset it zeroes one word per cycle, then sits in IDLE.
module dmem_clear_seq
    import dmem_bram_pkg::*;
#(
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] clrPtr_o,
    output logic                  clrWe_o,
    output logic                  idle_o
);

    localparam logic [ADDR_WIDTH-1:0] LastWord = ADDR_WIDTH'(DEPTH - 1);

    clearState_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clrPtr_q, clrPtr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrPtr_q <= '0;
        end else begin
            state_q  <= state_d;
            clrPtr_q <= clrPtr_d;
        end
    end

    // The write strobe is gated by rst so a reset edge never touches memory.
    always_comb begin
        state_d  = state_q;
        clrPtr_d = clrPtr_q;
        clrWe_o  = 1'b0;
        idle_o   = 1'b0;
        case (state_q)
            CLEAR: begin
                clrWe_o  = !rst;
                clrPtr_d = clrPtr_q + ADDR_WIDTH'(1);
                if (clrPtr_q == LastWord) begin
                    state_d  = IDLE;
                    clrPtr_d = '0;
                end
            end
            IDLE: begin
                idle_o = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign clrPtr_o = clrPtr_q;

endmodule

// File: rtl/dmem_bram.sv
// Byte-strobed single-port data memory with a post-reset clear sweep and 1-cycle read latency.
// Optional combinational debug read port enabled by defining DMEM_BRAM_DEBUG_PORT_EN.
module dmem_bram
    import dmem_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DMEM_BRAM_DEBUG_PORT_EN
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data,
`endif
    dmem_bram_if.slave            bus_if
);

    localparam int NumLanes = DATA_WIDTH / 8;

    generate
        if ((DATA_WIDTH % 8) != 0) begin : g_badWidth
            $error("dmem_bram: DATA_WIDTH must be a multiple of 8");
        end
        if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_badAddr
            $error("dmem_bram: ADDR_WIDTH too narrow for DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] clrPtr;
    logic                  clrWe;
    logic                  seqIdle;
    logic                  reqFire;
    logic                  inRange;

    logic                  rspValid_q;
    logic                  rspErr_q;
    logic [DATA_WIDTH-1:0] rspRdata_q;

    dmem_clear_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clearSeq (
        .clk      (clk),
        .rst      (rst),
        .clrPtr_o (clrPtr),
        .clrWe_o  (clrWe),
        .idle_o   (seqIdle)
    );

    assign reqFire = bus_if.req_valid && seqIdle && !rst;

    // A fully populated address space needs no range compare at all.
    generate
        if (DEPTH == (2 ** ADDR_WIDTH)) begin : g_fullRange
            assign inRange = 1'b1;
`ifdef DMEM_BRAM_DEBUG_PORT_EN
            assign debug_data = mem[debug_addr];
`endif
        end else begin : g_partialRange
            assign inRange = (32'(bus_if.req_addr) < 32'(DEPTH));
`ifdef DMEM_BRAM_DEBUG_PORT_EN
            assign debug_data = (32'(debug_addr) < 32'(DEPTH)) ? mem[debug_addr] : '0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clrWe) begin
                mem[clrPtr] <= '0;
            end else if (reqFire && bus_if.req_we && inRange) begin
                for (int b = 0; b < NumLanes; b++) begin
                    if (bus_if.req_wstrb[b]) begin
                        mem[bus_if.req_addr][b*8 +: 8] <= bus_if.req_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            rspValid_q <= reqFire && !bus_if.req_we;
            rspErr_q   <= reqFire && !inRange;
            if (reqFire && !bus_if.req_we) begin
                rspRdata_q <= inRange ? mem[bus_if.req_addr] : '0;
            end
        end
    end

    // A response whose cycle carries reset is dropped rather than presented.
    assign bus_if.req_ready = seqIdle;
    assign bus_if.init_busy = !seqIdle;
    assign bus_if.rsp_valid = rspValid_q && !rst;
    assign bus_if.rsp_err   = rspErr_q && !rst;
    assign bus_if.rsp_rdata = rspRdata_q;

endmodule
